// File: rtl/prm_edge_chk_sched_pkg.sv
// Shared types and constants for the PRM edge-check sequencer.
// Holds the sequencer state encoding and hit-count width helper.
package prm_chk_pkg;

    localparam int KEY_W = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    function automatic int hit_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/prm_edge_chk_sched_if.sv
// Command, edge-key RAM, checker-bank and result signals of the edge-check sequencer.
// master = surrounding planner/RAM/bank, slave = the sequencer.
interface prm_edge_chk_sched_if
    import prm_chk_pkg::*;
#(
    parameter int NUM_CHK = 8,
    parameter int EDGE_W  = 12,
    parameter int KEY_W   = prm_chk_pkg::KEY_W
);
    localparam int HIT_W = hit_w(NUM_CHK);

    logic                cmd_valid;
    logic                cmd_ready;
    logic [EDGE_W-1:0]   cmd_base;
    logic [EDGE_W:0]     cmd_count;
    logic                cmd_abort;

    logic                mem_rd_en;
    logic [EDGE_W-1:0]   mem_rd_addr;
    logic [KEY_W-1:0]    mem_rd_data;

    logic [KEY_W-1:0]    chk_key;
    logic [NUM_CHK-1:0]  chk_mask;

    logic                res_valid;
    logic                res_ready;
    logic [EDGE_W-1:0]   res_edge;
    logic                res_blocked;
    logic [HIT_W-1:0]    res_hits;

    modport master (
        output cmd_valid, cmd_base, cmd_count, cmd_abort,
        input  cmd_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  chk_key,
        output chk_mask,
        input  res_valid, res_edge, res_blocked, res_hits,
        output res_ready
    );

    modport slave (
        input  cmd_valid, cmd_base, cmd_count, cmd_abort,
        output cmd_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output chk_key,
        input  chk_mask,
        output res_valid, res_edge, res_blocked, res_hits,
        input  res_ready
    );

endinterface

// File: rtl/prm_edge_chk_sched_popcount.sv
// Combinational population count of a W-bit vector.
// Zero latency, no flow control.
module prm_popcount
    import prm_chk_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]          in_dat,
    output logic [hit_w(W)-1:0]   cnt
);
    localparam int CW = hit_w(W);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(in_dat[i]);
        end
    end

endmodule

// File: rtl/prm_edge_chk_sched.sv
// Edge-range sequencer: RAM read -> chk_key register -> result register, first result 4 cycles after accept.
// A stalled result (res_valid & !res_ready) freezes every stage and suppresses further RAM reads.
module prm_edge_chk_sched #(
    parameter int NUM_CHK = 8,
    parameter int EDGE_W  = 12,
    parameter int KEY_W   = prm_chk_pkg::KEY_W
) (
    input  logic                clk,
    input  logic                rst_n,
    prm_edge_chk_sched_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic [EDGE_W:0]     blk_total
);
    import prm_chk_pkg::*;

    localparam int              HIT_W   = hit_w(NUM_CHK);
    localparam logic [EDGE_W:0] CNT_ONE = {{EDGE_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [EDGE_W-1:0]   base_q, base_d;
    logic [EDGE_W:0]     count_q, count_d;
    logic [EDGE_W:0]     issued_q, issued_d;
    logic [EDGE_W:0]     blk_total_q, blk_total_d;
    logic                v0_q, v0_d, v1_q, v1_d;
    logic [EDGE_W-1:0]   e0_q, e0_d, e1_q, e1_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic                res_valid_q, res_valid_d;
    logic [EDGE_W-1:0]   res_edge_q, res_edge_d;
    logic                res_blocked_q, res_blocked_d;
    logic [HIT_W-1:0]    res_hits_q, res_hits_d;

    logic                en;
    logic                rd_issue;
    logic [EDGE_W-1:0]   rd_addr;
    logic [HIT_W-1:0]    mask_hits;

    prm_popcount #(.W(NUM_CHK)) u_popcount (
        .in_dat (bus.chk_mask),
        .cnt    (mask_hits)
    );

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        count_d       = count_q;
        issued_d      = issued_q;
        blk_total_d   = blk_total_q;
        v0_d          = v0_q;
        v1_d          = v1_q;
        e0_d          = e0_q;
        e1_d          = e1_q;
        key_d         = key_q;
        res_valid_d   = res_valid_q;
        res_edge_d    = res_edge_q;
        res_blocked_d = res_blocked_q;
        res_hits_d    = res_hits_q;

        en       = !res_valid_q || bus.res_ready;
        rd_addr  = base_q + issued_q[EDGE_W-1:0];
        rd_issue = (state_q == ST_RUN) && en && (issued_q < count_q);

        if (res_valid_q && bus.res_ready && res_blocked_q) begin
            blk_total_d = blk_total_q + CNT_ONE;
        end

        // All stages shift together so a stalled result never loses the key behind it.
        if (en) begin
            v0_d        = rd_issue;
            v1_d        = v0_q;
            res_valid_d = v1_q;
            if (rd_issue) begin
                e0_d = rd_addr;
            end
            if (v0_q) begin
                key_d = bus.mem_rd_data;
                e1_d  = e0_q;
            end
            if (v1_q) begin
                res_edge_d    = e1_q;
                res_blocked_d = |bus.chk_mask;
                res_hits_d    = mask_hits;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    base_d      = bus.cmd_base;
                    count_d     = bus.cmd_count;
                    issued_d    = '0;
                    blk_total_d = '0;
                    state_d     = (bus.cmd_count == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_issue) begin
                    issued_d = issued_q + CNT_ONE;
                    if (issued_q + CNT_ONE == count_q) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!v0_q && !v1_q && (!res_valid_q || bus.res_ready)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus.cmd_abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            v0_d        = 1'b0;
            v1_d        = 1'b0;
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            count_q       <= '0;
            issued_q      <= '0;
            blk_total_q   <= '0;
            v0_q          <= 1'b0;
            v1_q          <= 1'b0;
            e0_q          <= '0;
            e1_q          <= '0;
            key_q         <= '0;
            res_valid_q   <= 1'b0;
            res_edge_q    <= '0;
            res_blocked_q <= 1'b0;
            res_hits_q    <= '0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            count_q       <= count_d;
            issued_q      <= issued_d;
            blk_total_q   <= blk_total_d;
            v0_q          <= v0_d;
            v1_q          <= v1_d;
            e0_q          <= e0_d;
            e1_q          <= e1_d;
            key_q         <= key_d;
            res_valid_q   <= res_valid_d;
            res_edge_q    <= res_edge_d;
            res_blocked_q <= res_blocked_d;
            res_hits_q    <= res_hits_d;
        end
    end

    // Gated by rst_n so the port reads 0 while reset is held.
    assign bus.cmd_ready   = rst_n && (state_q == ST_IDLE);
    assign bus.mem_rd_en   = rd_issue;
    assign bus.mem_rd_addr = rd_addr;
    assign bus.chk_key     = key_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_edge    = res_edge_q;
    assign bus.res_blocked = res_blocked_q;
    assign bus.res_hits    = res_hits_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_FIN);
    assign blk_total       = blk_total_q;

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// Bench for prm_edge_chk_sched: RAM and bank models (chk_mask = chk_key[7:0]) plus a
// per-command expected-result queue built from the edge range and RAM contents.
module tb_prm_edge_chk_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        done;
    logic [12:0] blk_total;

    always #5 clk = ~clk;

    prm_edge_chk_sched_if #(.NUM_CHK(8), .EDGE_W(12), .KEY_W(15)) bus ();

    prm_edge_chk_sched #(.NUM_CHK(8), .EDGE_W(12), .KEY_W(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .blk_total (blk_total)
    );

    logic [14:0] mem [4096];

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    end

    assign bus.chk_mask = bus.chk_key[7:0];

    typedef struct {
        logic [11:0] e;
        logic        b;
        logic [3:0]  h;
    } res_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 ready=1, 1 random ready, 2 ready low in cycles 5..7, 3 foreign cmd_valid in cycle 2
    task automatic run_cmd(input logic [11:0] base, input int cnt, input int mode,
                           input int abort_after, input bit use_rst);
        res_t        exp_q[$];
        res_t        r;
        logic [11:0] a;
        int          rd_n = 0, n_res = 0, blk_m = 0, first = -1, done_c = -1, abort_c = -1;
        logic        pv = 1'b0, pr = 1'b0, pb = 1'b0;
        logic [11:0] pe = '0;
        logic [3:0]  ph = '0;

        for (int i = 0; i < cnt; i++) begin
            a   = 12'(base + i);
            r.e = a;
            r.b = |mem[a][7:0];
            r.h = 4'($countones(mem[a][7:0]));
            exp_q.push_back(r);
        end

        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_base  = base;
        bus.cmd_count = 13'(cnt);
        #1 chk("cmd_ready_idle", bus.cmd_ready, 1);

        for (int c = 1; c < 80 + 8 * cnt; c++) begin
            @(negedge clk);
            if (c == abort_c) begin
                #1;
                chk("abort_res_valid", bus.res_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                chk("abort_cmd_ready", bus.cmd_ready, use_rst ? 0 : 1);
                chk("abort_blk_total", blk_total, use_rst ? 0 : blk_m);
                if (use_rst) begin
                    chk("rst_mem_rd_en", bus.mem_rd_en, 0);
                    chk("rst_chk_key", bus.chk_key, 0);
                    chk("rst_res_edge", bus.res_edge, 0);
                    chk("rst_res_blocked", bus.res_blocked, 0);
                    chk("rst_res_hits", bus.res_hits, 0);
                end
                bus.cmd_abort = 1'b0;
                rst_n = 1'b1;
                @(negedge clk);
                #1;
                chk("post_abort_cmd_ready", bus.cmd_ready, 1);
                chk("post_abort_done", done, 0);
                break;
            end
            bus.cmd_valid = (mode == 3 && c == 2);
            if (bus.cmd_valid) bus.cmd_base = base ^ 12'h800;
            bus.res_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) :
                            (mode == 2) ? !(c >= 5 && c <= 7) : 1'b1;
            #1;
            if (mode == 3 && c == 2) chk("busy_cmd_ready", bus.cmd_ready, 0);
            if (bus.mem_rd_en) begin
                chk("rd_addr", bus.mem_rd_addr, 12'(base + rd_n));
                rd_n++;
            end
            if (bus.res_valid && !bus.res_ready) chk("stall_no_rd", bus.mem_rd_en, 0);
            if (pv && !pr) begin
                chk("hold_valid", bus.res_valid, 1);
                chk("hold_edge", bus.res_edge, pe);
                chk("hold_blocked", bus.res_blocked, pb);
                chk("hold_hits", bus.res_hits, ph);
            end
            if (bus.res_valid && first < 0) first = c;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) chk("extra_res", bus.res_valid, 0);
                else begin
                    r = exp_q.pop_front();
                    chk("res_edge", bus.res_edge, r.e);
                    chk("res_blocked", bus.res_blocked, r.b);
                    chk("res_hits", bus.res_hits, r.h);
                    blk_m += int'(r.b);
                end
                n_res++;
            end
            pv = bus.res_valid; pr = bus.res_ready;
            pe = bus.res_edge;  pb = bus.res_blocked; ph = bus.res_hits;
            if (done) begin
                done_c = c;
                break;
            end
            if (abort_after >= 0 && abort_c < 0 && n_res >= abort_after) begin
                if (use_rst) rst_n = 1'b0;
                else bus.cmd_abort = 1'b1;
                abort_c = c + 1;
            end
        end

        if (abort_c < 0) begin
            chk("done_seen", (done_c >= 0), 1);
            chk("num_reads", rd_n, cnt);
            chk("num_results", n_res, cnt);
            chk("blk_total", blk_total, blk_m);
            if (mode != 1) begin
                chk("done_cycle", done_c, (cnt == 0) ? 1 : ((mode == 2) ? cnt + 7 : cnt + 4));
                if (cnt > 0) chk("first_res_cycle", first, 4);
            end
            @(negedge clk);
            #1;
            chk("done_pulse_end", done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_cmd_ready", bus.cmd_ready, 1);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_count = '0;
        bus.cmd_abort = 1'b0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = 15'($urandom);

        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_res_valid", bus.res_valid, 0);
        chk("reset_mem_rd_en", bus.mem_rd_en, 0);
        chk("reset_blk_total", blk_total, 0);
        chk("reset_chk_key", bus.chk_key, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("release_cmd_ready", bus.cmd_ready, 1);

        // Basic run
        mem[5] = 15'h00FF;
        mem[6] = 15'h0000;
        mem[7] = 15'h0003;
        run_cmd(12'd5, 3, 0, -1, 1'b0);
        chk("basic_blk_total", blk_total, 2);

        run_cmd(12'hFFE, 4, 0, -1, 1'b0);
        run_cmd(12'd100, 6, 2, -1, 1'b0);
        run_cmd(12'd300, 0, 0, -1, 1'b0);
        chk("empty_blk_total", blk_total, 0);
        run_cmd(12'd40, 5, 3, -1, 1'b0);
        run_cmd(12'd200, 10, 0, 2, 1'b0);
        run_cmd(12'd200, 10, 0, 2, 1'b1);
        run_cmd(12'd7, 2, 0, -1, 1'b0);

        for (int k = 0; k < 8; k++) begin
            run_cmd(12'($urandom), $urandom_range(0, 20), 1, -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prm_edge_chk_sched.md
# prm_edge_chk_sched

Sequencer for the PRM obstacle-logic checker bank. It accepts a command naming a contiguous range of roadmap edges and fetches each edge's 15-bit configuration key from the edge-key RAM. It drives the key onto the shared checker bank and reduces the returned per-checker mask into a blocked flag and hit count. It streams one result per edge, reports a per-command blocked total, and sits between the planner's command path and the combinational `prm_oblgc_chk*` instances.

## Interface
- `NUM_CHK`, default 8: number of checker instances in the bank (mask width).
- `EDGE_W`, default 12: edge index width; addresses wrap modulo 2^EDGE_W.
- `KEY_W`, default 15: key width, one bit per checker input A..O (bit 0 = A).
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `cmd_valid` / `cmd_ready`, in / out, 1 bit each: command handshake.
- `cmd_base` input, EDGE_W bits: first edge index.
- `cmd_count` input, EDGE_W+1 bits: number of edges. 0 is legal.
- `cmd_abort` input, 1 bit: synchronous abort of the current command.
- `mem_rd_en` output, 1 bit: edge-key RAM read strobe.
- `mem_rd_addr` output, EDGE_W bits: edge-key RAM read address.
- `mem_rd_data` input, KEY_W bits: key from the RAM. Valid the cycle after `mem_rd_en` and held until the next `mem_rd_en`.
- `chk_key` output, KEY_W bits: registered key broadcast to the checker bank.
- `chk_mask` input, NUM_CHK bits: combinational `edge_mask` outputs of the bank for the current `chk_key`.
- `res_valid` / `res_ready`, out / in, 1 bit each: result stream handshake.
- `res_edge` output, EDGE_W bits: edge index of the result.
- `res_blocked` output, 1 bit: OR-reduction of `chk_mask`.
- `res_hits` output, $clog2(NUM_CHK+1) bits: popcount of `chk_mask`.
- `busy` output, 1 bit: a command is in progress.
- `done` output, 1 bit: single-cycle pulse on command completion.
- `blk_total` output, EDGE_W+1 bits: number of blocked edges in the last command. Valid from the `done` pulse until the next command is accepted.

## Operation
- FSM states are IDLE, RUN, DRAIN and FIN.
  - IDLE: `cmd_ready`=1. A handshake latches base and count and clears `blk_total`. The next state is RUN, or FIN if count is 0.
  - RUN: issue reads at `mem_rd_addr` = base+i (mod 2^EDGE_W). After the last issue, go to DRAIN.
  - DRAIN: wait until the pipe is empty and the last result is accepted, then go to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
- Pipeline: S0 (read in flight, v0), then S1 (`chk_key` register, v1, edge e1), then OUT (result registers).
  - Global advance enable: `en` = !res_valid | res_ready.
  - `mem_rd_en` = RUN & `en` & issued<count.
  - On `en`: S1 loads `mem_rd_data` if v0; OUT loads the edge, `|chk_mask` and popcount if v1.
  - When `en`=0, every stage holds, `chk_key` stays stable, and no read is issued.
- `blk_total` increments on each accepted result with `res_blocked`=1.
- `busy` = state != IDLE.
- `cmd_valid` outside IDLE is ignored (`cmd_ready`=0).
- `cmd_abort`, in any non-IDLE state:
  - next cycle: state IDLE, all valid bits 0, `res_valid`=0.
  - no `done` pulse; `blk_total` keeps its partial value.
  - `cmd_abort` in IDLE is a no-op.
- `rst_n`=0 acts like abort, and additionally zeroes every register.
- Reset values: all outputs 0, state IDLE. `cmd_ready` reads 1 from the first cycle after reset release.

## Timing
- Command handshake in cycle 0, then:
  - cycle 1: first `mem_rd_en`.
  - cycle 2: `mem_rd_data` valid.
  - cycle 3: `chk_key` valid, `chk_mask` sampled.
  - cycle 4: first `res_valid`.
- With `res_ready`=1, throughput is 1 edge/cycle. The last result is in cycle count+3, and `done` is in the cycle after its acceptance.
- count=0: `done` in cycle 1, no reads issued.
- `res_*` are stable while `res_valid`=1 and `res_ready`=0. A result is never dropped or duplicated.
- The bank path is combinational within one cycle: `chk_key` register to `chk_mask` to OUT register.

## Structure
- Package `prm_chk_pkg` holds:
  - the FSM state enum.
  - `KEY_W`=15 as the default constant.
  - a function for the hit-count width.
- Sub-module `prm_popcount`, parameterised by width: a combinational popcount of `chk_mask`, instantiated once.
- The checker bank is outside this block. The top level wires `chk_key` bits to inputs A..O of each `prm_oblgc_chk*` instance and concatenates their `edge_mask` outputs into `chk_mask`.

## Test plan
All scenarios use NUM_CHK=8 and a bank model with `chk_mask` = `chk_key[7:0]`.
- **Basic run:** base=5, count=3, mem[5..7] = 0x00FF, 0x0000, 0x0003, `res_ready`=1.
  - Results (edge, blocked, hits): (5,1,8), (6,0,0), (7,1,2).
  - First `res_valid` in cycle 4, `done` in cycle 7, `blk_total`=2.
- **Address wrap:** EDGE_W=12, base=0xFFE, count=4. Read addresses are 0xFFE, 0xFFF, 0x000, 0x001, and `res_edge` follows the same order.
- **Backpressure:** `res_ready`=0 for 3 cycles while result 2 is presented.
  - Result 2 is held stable and `mem_rd_en`=0 during the stall.
  - All results arrive exactly once, in order.
- **Empty command:** count=0 gives `done` in cycle 1, no `mem_rd_en`, no `res_valid`, `blk_total`=0.
- **Mid-run abort:** `cmd_abort` after 2 results of a count=10 command.
  - Next cycle: `res_valid`=0, `busy`=0, `cmd_ready`=1, no `done`.
  - Repeating with `rst_n`=0 instead also zeroes all outputs.
- **Command while busy:** `cmd_valid` asserted during RUN with a different base is not accepted (`cmd_ready`=0), and the current command completes unchanged.
